// File: rtl/muldiv_sequencer.sv
// Iterative RISC-V M-extension multiply/divide unit.
// One shift-add or restoring shift-subtract step per cycle over XLEN cycles,
// followed by a single writeback cycle. Signed ops work on magnitudes and
// negate the final value.
module muldiv_sequencer #(
   parameter int XLEN = 32,
   parameter int CNTW = 6
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            req_valid,
   input  logic [3:0]      mul_op,
   input  logic [3:0]      div_op,
   input  logic [XLEN-1:0] rdata1,
   input  logic [XLEN-1:0] rdata2,
   input  logic [4:0]      req_waddr,
   input  logic            flush,
   output logic            req_ready,
   output logic            stall,
   output logic            res_valid,
   output logic [XLEN-1:0] res_data,
   output logic [4:0]      res_waddr
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [CNTW-1:0] LAST_STEP = CNTW'(XLEN - 1);

   logic [1:0]        state;
   logic [CNTW-1:0]   cnt;
   logic              is_div, is_rem, is_hi, neg_res;
   logic [XLEN-1:0]   opnd;      // multiplicand or divisor magnitude
   logic [2*XLEN-1:0] acc;       // mul: {partial, multiplier}; div: {remainder, quotient}
   logic [4:0]        waddr_q;

   // Conditional two's-complement negation, single and double width.
   function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic n);
      return n ? (~v + XLEN'(1)) : v;
   endfunction

   function automatic logic [2*XLEN-1:0] cneg2(input logic [2*XLEN-1:0] v, input logic n);
      return n ? (~v + (2*XLEN)'(1)) : v;
   endfunction

   logic [7:0]      ops;
   logic            any_op, accept;
   logic            d_div, d_rem, d_hi, d_sa, d_sb;
   logic            a_neg, b_neg, b_zero, d_neg;
   logic [XLEN-1:0] a_mag, b_mag;

   // Priority decode of the op bits; lowest index wins.
   always_comb begin
      ops   = {div_op, mul_op};
      d_div = 1'b0;
      d_rem = 1'b0;
      d_hi  = 1'b0;
      d_sa  = 1'b0;
      d_sb  = 1'b0;
      if (ops[0]) begin
         d_hi = 1'b0;                                   // mul: low half is sign-agnostic
      end else if (ops[1]) begin
         d_hi = 1'b1; d_sa = 1'b1; d_sb = 1'b1;          // mulh
      end else if (ops[2]) begin
         d_hi = 1'b1; d_sa = 1'b1;                       // mulhsu
      end else if (ops[3]) begin
         d_hi = 1'b1;                                    // mulhu
      end else if (ops[4]) begin
         d_div = 1'b1; d_sa = 1'b1; d_sb = 1'b1;         // div
      end else if (ops[5]) begin
         d_div = 1'b1;                                   // divu
      end else if (ops[6]) begin
         d_div = 1'b1; d_rem = 1'b1; d_sa = 1'b1; d_sb = 1'b1; // rem
      end else if (ops[7]) begin
         d_div = 1'b1; d_rem = 1'b1;                     // remu
      end
   end

   assign any_op = |ops;
   assign accept = (state == S_IDLE) && req_valid && any_op && !flush;
   assign a_neg  = d_sa & rdata1[XLEN-1];
   assign b_neg  = d_sb & rdata2[XLEN-1];
   assign b_zero = (rdata2 == '0);
   assign a_mag  = cneg(rdata1, a_neg);
   assign b_mag  = cneg(rdata2, b_neg);
   // Divide by zero keeps the quotient all-ones; remainder follows the dividend.
   assign d_neg  = d_div ? (d_rem ? a_neg : ((a_neg ^ b_neg) & ~b_zero)) : (a_neg ^ b_neg);

   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shift;
   logic              div_ge;
   logic [XLEN-1:0]   div_diff;
   logic [2*XLEN-1:0] acc_step;

   // One iteration of the shift-add multiplier or restoring divider.
   always_comb begin
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
      div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_ge    = (div_shift >= {1'b0, opnd});
      div_diff  = XLEN'(div_shift - {1'b0, opnd});
      if (is_div) begin
         if (div_ge) acc_step = {div_diff, acc[XLEN-2:0], 1'b1};
         else        acc_step = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end else begin
         acc_step = {mul_sum, acc[XLEN-1:1]};
      end
   end

   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   div_val, result;

   // Sign fix-up and half selection of the finished value.
   always_comb begin
      prod_s  = cneg2(acc, neg_res);
      div_val = is_rem ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
      if (is_div)     result = cneg(div_val, neg_res);
      else if (is_hi) result = prod_s[2*XLEN-1:XLEN];
      else            result = prod_s[XLEN-1:0];
   end

   assign req_ready = (state == S_IDLE);
   assign stall     = ((state == S_IDLE) && req_valid && any_op) || (state != S_IDLE);
   assign res_valid = (state == S_DONE) && !flush;
   assign res_data  = res_valid ? result  : '0;
   assign res_waddr = res_valid ? waddr_q : '0;

   // Sequencer state, iteration counter and datapath registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         is_div  <= 1'b0;
         is_rem  <= 1'b0;
         is_hi   <= 1'b0;
         neg_res <= 1'b0;
         opnd    <= '0;
         acc     <= '0;
         waddr_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state   <= S_BUSY;
                  cnt     <= '0;
                  is_div  <= d_div;
                  is_rem  <= d_rem;
                  is_hi   <= d_hi;
                  neg_res <= d_neg;
                  opnd    <= d_div ? b_mag : a_mag;
                  acc     <= {{XLEN{1'b0}}, (d_div ? a_mag : b_mag)};
                  waddr_q <= req_waddr;
               end
            end
            S_BUSY: begin
               if (flush) begin
                  state <= S_IDLE;
                  cnt   <= '0;
               end else begin
                  acc <= acc_step;
                  cnt <= cnt + CNTW'(1);
                  if (cnt == LAST_STEP) state <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               if (flush) cnt <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with hand-computed results.
module tb_muldiv_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic [3:0]  mul_op = '0;
   logic [3:0]  div_op = '0;
   logic [31:0] rdata1 = '0;
   logic [31:0] rdata2 = '0;
   logic [4:0]  req_waddr = '0;
   logic        flush = 1'b0;
   logic        req_ready, stall, res_valid;
   logic [31:0] res_data;
   logic [4:0]  res_waddr;

   int checks = 0;
   int failures = 0;

   muldiv_sequencer #(.XLEN(32), .CNTW(6)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .mul_op(mul_op), .div_op(div_op),
      .rdata1(rdata1), .rdata2(rdata2), .req_waddr(req_waddr), .flush(flush),
      .req_ready(req_ready), .stall(stall), .res_valid(res_valid), .res_data(res_data),
      .res_waddr(res_waddr)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   // Issue one request, then look for res_valid on up to 40 falling edges.
   // lat is the cycle index (1 = first cycle after the acceptance edge), -1 if none.
   task automatic do_op(input logic [3:0] mop, input logic [3:0] dop, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wa,
                        output logic [31:0] d, output logic [4:0] w, output int lat);
      @(negedge clock);
      mul_op = mop; div_op = dop; rdata1 = a; rdata2 = b; req_waddr = wa; req_valid = 1'b1;
      @(posedge clock);
      #1;
      req_valid = 1'b0; mul_op = '0; div_op = '0;
      lat = -1; d = '0; w = '0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clock);
         if (res_valid) begin
            lat = i; d = res_data; w = res_waddr;
            break;
         end
      end
      @(negedge clock);
   endtask

   task automatic test_reset();
      #3;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall); end
      checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", res_valid); end
      checks++; if (res_data !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", res_data); end
      checks++; if (res_waddr !== 5'h0) begin failures++; $display("FAIL rst_waddr got=%h exp=0", res_waddr); end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_mul();
      logic [31:0] d; logic [4:0] w; int lat;
      do_op(4'b0001, 4'b0000, 32'd7, 32'hFFFFFFFD, 5'd5, d, w, lat);
      checks++; if (lat !== 33) begin failures++; $display("FAIL mul_latency got=%0d exp=33", lat); end
      checks++; if (d !== 32'hFFFFFFEB) begin failures++; $display("FAIL mul_data got=%h exp=ffffffeb", d); end
      checks++; if (w !== 5'd5) begin failures++; $display("FAIL mul_waddr got=%0d exp=5", w); end
      checks++; if (res_data !== 32'h0 || res_waddr !== 5'h0) begin failures++; $display("FAIL idle_zero got=%h/%h exp=0/0", res_data, res_waddr); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL mul_ready_after got=%b exp=1", req_ready); end
      do_op(4'b1000, 4'b0000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, d, w, lat);
      checks++; if (d !== 32'hFFFFFFFE || lat !== 33) begin failures++; $display("FAIL mulhu got=%h lat=%0d exp=fffffffe lat=33", d, lat); end
      do_op(4'b0100, 4'b0000, 32'hFFFFFFFF, 32'd2, 5'd7, d, w, lat);
      checks++; if (d !== 32'hFFFFFFFF) begin failures++; $display("FAIL mulhsu got=%h exp=ffffffff", d); end
      do_op(4'b0010, 4'b0000, 32'hFFFFFFFE, 32'd3, 5'd7, d, w, lat);
      checks++; if (d !== 32'hFFFFFFFF) begin failures++; $display("FAIL mulh_neg got=%h exp=ffffffff", d); end
   endtask

   task automatic test_div();
      logic [31:0] d; logic [4:0] w; int lat;
      do_op(4'b0000, 4'b0001, 32'hFFFFFFEC, 32'd3, 5'd8, d, w, lat);
      checks++; if (d !== 32'hFFFFFFFA || lat !== 33) begin failures++; $display("FAIL div got=%h lat=%0d exp=fffffffa lat=33", d, lat); end
      do_op(4'b0000, 4'b0100, 32'hFFFFFFEC, 32'd3, 5'd9, d, w, lat);
      checks++; if (d !== 32'hFFFFFFFE) begin failures++; $display("FAIL rem got=%h exp=fffffffe", d); end
      do_op(4'b0000, 4'b0010, 32'd20, 32'd3, 5'd10, d, w, lat);
      checks++; if (d !== 32'd6 || w !== 5'd10) begin failures++; $display("FAIL divu got=%h/%0d exp=6/10", d, w); end
      do_op(4'b0000, 4'b1000, 32'd20, 32'd3, 5'd11, d, w, lat);
      checks++; if (d !== 32'd2) begin failures++; $display("FAIL remu got=%h exp=2", d); end
   endtask

   task automatic test_corners();
      logic [31:0] d; logic [4:0] w; int lat;
      do_op(4'b0000, 4'b0010, 32'd5, 32'd0, 5'd1, d, w, lat);
      checks++; if (d !== 32'hFFFFFFFF || lat !== 33) begin failures++; $display("FAIL divu_by0 got=%h lat=%0d exp=ffffffff lat=33", d, lat); end
      do_op(4'b0000, 4'b0100, 32'd5, 32'd0, 5'd1, d, w, lat);
      checks++; if (d !== 32'd5) begin failures++; $display("FAIL rem_by0 got=%h exp=5", d); end
      do_op(4'b0000, 4'b0001, 32'hFFFFFFF9, 32'd0, 5'd1, d, w, lat);
      checks++; if (d !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_neg_by0 got=%h exp=ffffffff", d); end
      do_op(4'b0000, 4'b0100, 32'hFFFFFFF9, 32'd0, 5'd1, d, w, lat);
      checks++; if (d !== 32'hFFFFFFF9) begin failures++; $display("FAIL rem_neg_by0 got=%h exp=fffffff9", d); end
      do_op(4'b0000, 4'b0001, 32'h80000000, 32'hFFFFFFFF, 5'd2, d, w, lat);
      checks++; if (d !== 32'h80000000) begin failures++; $display("FAIL div_ovf got=%h exp=80000000", d); end
      do_op(4'b0000, 4'b0100, 32'h80000000, 32'hFFFFFFFF, 5'd2, d, w, lat);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL rem_ovf got=%h exp=0", d); end
   endtask

   task automatic test_priority();
      logic [31:0] d; logic [4:0] w; int lat;
      // mulh beats mulhsu: (-1)*(-1) = 1, high half 0 (mulhsu would give ffffffff)
      do_op(4'b0110, 4'b0000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, d, w, lat);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL prio_mulh got=%h exp=0", d); end
      // mul beats div: 6*7 = 42
      do_op(4'b0001, 4'b0001, 32'd6, 32'd7, 5'd3, d, w, lat);
      checks++; if (d !== 32'd42) begin failures++; $display("FAIL prio_mul got=%h exp=2a", d); end
      // divu beats rem: 20/3 = 6
      do_op(4'b0000, 4'b0110, 32'd20, 32'd3, 5'd3, d, w, lat);
      checks++; if (d !== 32'd6) begin failures++; $display("FAIL prio_divu got=%h exp=6", d); end
   endtask

   task automatic test_no_op_and_idle_flush();
      @(negedge clock);
      req_valid = 1'b1; mul_op = '0; div_op = '0; rdata1 = 32'd9; rdata2 = 32'd3;
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL noop_stall got=%b exp=0", stall); end
      @(negedge clock);
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL noop_ignored got=%b exp=1", req_ready); end
      div_op = 4'b0010; flush = 1'b1;
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL req_stall got=%b exp=1", stall); end
      @(negedge clock);
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL idle_flush_block got=%b exp=1", req_ready); end
      req_valid = 1'b0; div_op = '0; flush = 1'b0;
   endtask

   task automatic test_flush_busy();
      int seen;
      @(negedge clock);
      mul_op = 4'b0001; rdata1 = 32'd3; rdata2 = 32'd4; req_waddr = 5'd12; req_valid = 1'b1;
      @(posedge clock);
      #1;
      req_valid = 1'b0; mul_op = '0;
      repeat (10) @(negedge clock);
      checks++; if (stall !== 1'b1 || req_ready !== 1'b0) begin failures++; $display("FAIL busy_flags got=%b/%b exp=1/0", stall, req_ready); end
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL flush_busy_ready got=%b exp=1", req_ready); end
      seen = 0;
      repeat (40) begin @(negedge clock); if (res_valid) seen++; end
      checks++; if (seen !== 0) begin failures++; $display("FAIL flush_busy_valid got=%0d exp=0", seen); end
   endtask

   task automatic test_flush_done();
      @(negedge clock);
      mul_op = 4'b0001; rdata1 = 32'd3; rdata2 = 32'd4; req_waddr = 5'd13; req_valid = 1'b1;
      @(posedge clock);
      #1;
      req_valid = 1'b0; mul_op = '0;
      repeat (33) @(negedge clock);
      checks++; if (res_valid !== 1'b1 || res_data !== 32'd12) begin failures++; $display("FAIL done_pre got=%b/%h exp=1/c", res_valid, res_data); end
      flush = 1'b1;
      #1;
      checks++; if (res_valid !== 1'b0 || res_data !== 32'h0) begin failures++; $display("FAIL flush_done got=%b/%h exp=0/0", res_valid, res_data); end
      @(negedge clock);
      flush = 1'b0;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL flush_done_ready got=%b exp=1", req_ready); end
   endtask

   task automatic test_back_to_back();
      int c1, c2, busy_ready;
      logic [31:0] d1, d2; logic [4:0] w1, w2;
      c1 = -1; c2 = -1; busy_ready = 0; d1 = '0; d2 = '0; w1 = '0; w2 = '0;
      @(negedge clock);
      div_op = 4'b0010; rdata1 = 32'd20; rdata2 = 32'd3; req_waddr = 5'd3; req_valid = 1'b1;
      @(posedge clock);
      for (int i = 1; i <= 80; i++) begin
         @(negedge clock);
         if (i == 5) begin div_op = '0; mul_op = 4'b0001; rdata1 = 32'd7; rdata2 = 32'd6; req_waddr = 5'd4; end
         if (i == 35) begin req_valid = 1'b0; mul_op = '0; end
         if (i > 1 && i < 33 && req_ready) busy_ready++;
         if (res_valid && c1 < 0) begin c1 = i; d1 = res_data; w1 = res_waddr; end
         else if (res_valid && c2 < 0) begin c2 = i; d2 = res_data; w2 = res_waddr; end
      end
      checks++; if (busy_ready !== 0) begin failures++; $display("FAIL b2b_ready_busy got=%0d exp=0", busy_ready); end
      checks++; if (c1 !== 33 || d1 !== 32'd6 || w1 !== 5'd3) begin failures++; $display("FAIL b2b_first got=%0d/%h/%0d exp=33/6/3", c1, d1, w1); end
      checks++; if (c2 !== 67 || d2 !== 32'd42 || w2 !== 5'd4) begin failures++; $display("FAIL b2b_second got=%0d/%h/%0d exp=67/2a/4", c2, d2, w2); end
   endtask

   task automatic test_reset_mid();
      int seen; logic [31:0] d; logic [4:0] w; int lat;
      @(negedge clock);
      div_op = 4'b0010; rdata1 = 32'd100; rdata2 = 32'd7; req_waddr = 5'd14; req_valid = 1'b1;
      @(posedge clock);
      #1;
      req_valid = 1'b0; div_op = '0;
      repeat (15) @(negedge clock);
      #2;
      reset = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL rst_mid_flags got=%b/%b exp=1/0", req_ready, stall); end
      checks++; if (res_valid !== 1'b0 || res_data !== 32'h0 || res_waddr !== 5'h0) begin failures++; $display("FAIL rst_mid_out got=%b/%h/%h exp=0/0/0", res_valid, res_data, res_waddr); end
      @(negedge clock);
      reset = 1'b0;
      seen = 0;
      repeat (40) begin @(negedge clock); if (res_valid) seen++; end
      checks++; if (seen !== 0) begin failures++; $display("FAIL rst_mid_valid got=%0d exp=0", seen); end
      do_op(4'b0000, 4'b0010, 32'd100, 32'd7, 5'd15, d, w, lat);
      checks++; if (d !== 32'd14 || w !== 5'd15 || lat !== 33) begin failures++; $display("FAIL rst_mid_after got=%h/%0d/%0d exp=e/15/33", d, w, lat); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_corners();
      test_priority();
      test_no_op_and_idle_flush();
      test_flush_busy();
      test_flush_done();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
